apb_req_arbiter: RTL
====================

// Module: apb_req_arbiter
//
// PURPOSE
//   Shares one APB requester (bridge-side) port between NUM_REQ internal clients.
//   Uses round-robin arbitration and sequences each granted request through the
//   APB SETUP and ACCESS phases.
//   Returns read data and error status to the winning client.
//   Adds an ACCESS-phase timeout so a completer that never raises pready cannot hang the bus.
//   Sits between the internal clients and the apb_if bridge modport.
//
// PARAMETERS
//   NUM_REQ     4   number of clients, >=2
//   ADDR_WIDTH  32  paddr width
//   DATA_WIDTH  32  pwdata/prdata width
//   STRB_WIDTH  4   pstrb width (DATA_WIDTH/8)
//   TIMEOUT     16  ACCESS cycles without pready before abort; 0 disables the timeout
//
// PORTS
//   pclk       in   1                      APB clock; all logic on rising edge
//   preset     in   1                      reset, synchronous, active-high
//   req_valid  in   NUM_REQ                per-client request; held until that client's rsp_valid
//   req_addr   in   NUM_REQ*ADDR_WIDTH     per-client address, client i at slice i
//   req_write  in   NUM_REQ                per-client 1=write, 0=read
//   req_wdata  in   NUM_REQ*DATA_WIDTH     per-client write data
//   req_strb   in   NUM_REQ*STRB_WIDTH     per-client byte strobes
//   req_prot   in   NUM_REQ*3              per-client pprot value
//   req_gnt    out  NUM_REQ                one-hot, 1-cycle pulse when request is captured
//   rsp_valid  out  NUM_REQ                one-hot, 1-cycle pulse when transfer completes
//   rsp_rdata  out  DATA_WIDTH             read data, valid with rsp_valid
//   rsp_err    out  1                      pslverr or timeout, valid with rsp_valid
//   paddr, psel, penable, pwrite, pwdata, pstrb, pprot   out   APB bridge outputs
//   prdata, pready, pslverr                               in    APB bridge inputs
//
// BEHAVIOUR
//   - All outputs are registered.
//   - On reset, every output is 0, the FSM is in IDLE, and the priority pointer is set
//     so that client 0 wins first.
//   - FSM has three states: IDLE, SETUP, ACCESS.
//   - IDLE:
//     - Arbitrate among req_valid, excluding any client whose rsp_valid is high this cycle.
//     - Search starts at last winner+1 and wraps modulo NUM_REQ.
//     - On a winner g: latch g's addr/write/wdata/strb/prot into the APB outputs,
//       pulse req_gnt[g], set psel=1 and penable=0, go to SETUP.
//   - SETUP: unconditionally go to ACCESS with penable=1.
//   - ACCESS, pready=1:
//     - Clear psel and penable, pulse rsp_valid[g].
//     - rsp_rdata = prdata on reads, 0 on writes; rsp_err = pslverr.
//     - Update the priority pointer to g, go to IDLE.
//   - ACCESS, pready=0: hold every APB output and increment the wait counter.
//   - Timeout: when the wait counter reaches TIMEOUT (TIMEOUT>0), abort.
//     - Clear psel and penable, pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0.
//     - Update the pointer, go to IDLE.
//     - A late pready is then ignored.
//   - Wait counter is $clog2(TIMEOUT+1) bits and clears on entry to SETUP.
//   - Latency: capture edge to rsp_valid is 3 cycles minimum (IDLE->SETUP->ACCESS->IDLE),
//     plus one cycle per wait state. There is at least one IDLE cycle between transfers.
//   - paddr, pwrite, pwdata and pprot hold their values outside transfers.
//   - pstrb is forced to 0 for reads.
//   - Client drops req_valid after grant: ignored; the transfer completes and responds.
//   - Reset asserted mid-transfer: psel, penable and all pulses go to 0 at the next edge,
//     and no rsp_valid is issued.
//   - Exactly one client is granted per IDLE cycle.
//   - req_gnt and rsp_valid are never multi-hot.
//
// TESTING
//   1. Hold preset=1 for 2 cycles with all req_valid=1 -> all outputs 0;
//      first grant after release goes to client 0.
//   2. Client0 write addr=0x10, wdata=0xDEADBEEF, strb=0xF, pready=1:
//      - T+1: psel=1, penable=0.
//      - T+2: penable=1.
//      - T+3: rsp_valid=0001, rsp_err=0.
//   3. Client2 read with pready low for 3 ACCESS cycles, then high with prdata=0x1234 ->
//      pstrb=0, rsp_valid=0100, rsp_rdata=0x1234, 6 cycles after grant.
//   4. All four clients requesting continuously -> grant order 0,1,2,3,0,1;
//      no client granted twice in a row.
//   5. pready never asserted, TIMEOUT=16 -> after 16 ACCESS cycles rsp_err=1, rsp_rdata=0,
//      psel drops; a late pready has no effect.
//   6. pslverr=1 with pready -> rsp_err=1.
//      preset pulsed during ACCESS -> psel=penable=0 next cycle, no rsp_valid.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// APB requester/completer signal bundle shared by the arbiter and the bridge.
interface apb_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB requester port between NUM_REQ clients,
// with SETUP/ACCESS sequencing and an ACCESS-phase timeout.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                                  pclk,
  input  logic                                  preset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]    req_strb,
  input  logic [NUM_REQ-1:0][2:0]               req_prot,
  output logic [NUM_REQ-1:0]                    req_gnt,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  rsp_err,
  apb_req_arbiter_if.master                     apb
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d, cur_q, cur_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  write_q, write_d, psel_q, psel_d, pen_q, pen_d;
  logic [NUM_REQ-1:0]    gnt_d, rspv_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;

  logic [NUM_REQ-1:0]    elig;
  logic [IDX_W-1:0]      scan_idx, win_idx;
  logic                  win_vld;
  logic                  timeout_hit;

  // A client whose response is going out this cycle must not be re-granted immediately.
  always_comb begin
    elig     = req_valid & ~rsp_valid;
    win_vld  = 1'b0;
    win_idx  = last_q;
    scan_idx = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_vld && elig[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    write_d = write_q;
    psel_d  = psel_q;
    pen_d   = pen_q;
    gnt_d   = '0;
    rspv_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          addr_d         = req_addr[win_idx];
          write_d        = req_write[win_idx];
          wdata_d        = req_wdata[win_idx];
          strb_d         = req_write[win_idx] ? req_strb[win_idx] : '0;
          prot_d         = req_prot[win_idx];
          gnt_d[win_idx] = 1'b1;
          cur_d          = win_idx;
          cnt_d          = '0;
          psel_d         = 1'b1;
          pen_d          = 1'b0;
          state_d        = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.pready) begin
          psel_d        = 1'b0;
          pen_d         = 1'b0;
          rspv_d[cur_q] = 1'b1;
          rdata_d       = write_q ? '0 : apb.prdata;
          err_d         = apb.pslverr;
          last_d        = cur_q;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          pen_d         = 1'b0;
          rspv_d[cur_q] = 1'b1;
          err_d         = 1'b1;
          last_d        = cur_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset parks the pointer on the last client so client 0 wins first.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cur_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      write_q   <= 1'b0;
      psel_q    <= 1'b0;
      pen_q     <= 1'b0;
      req_gnt   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      write_q   <= write_d;
      psel_q    <= psel_d;
      pen_q     <= pen_d;
      req_gnt   <= gnt_d;
      rsp_valid <= rspv_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  assign apb.paddr   = addr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = pen_q;
  assign apb.pwrite  = write_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = strb_q;
  assign apb.pprot   = prot_q;

endmodule
